// File: rtl/qpsk_deint_rx_pkg.sv
// Shared WiMax PHY constants, FSM state types and sample helpers for the QPSK receive deinterleaver.
// Build option: RX_ERASURE_EN enables the per-bit erasure path in the files that import this package.
package wimax_phy_pkg;

    localparam int NCBPS_QPSK = 384;
    localparam int INTLV_D    = 16;
    localparam int INTLV_ROWS = NCBPS_QPSK / INTLV_D;
    localparam int SAMPLE_W   = 16;
    localparam logic signed [SAMPLE_W-1:0] QPSK_AMP = 16'sd23170;

    typedef enum logic {
        W_FILL,
        W_WAIT
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rstate_t;

    // Saturating magnitude: the most negative code maps to the largest positive one.
    function automatic logic [SAMPLE_W-1:0] sample_mag(input logic signed [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] mag;
        if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (s[SAMPLE_W-1]) begin
            mag = $unsigned(-s);
        end else begin
            mag = $unsigned(s);
        end
        return mag;
    endfunction

endpackage

// File: rtl/qpsk_deint_rx_if.sv
// Symbol-in / coded-bit-out bundle of the QPSK deinterleaver.
// Build option: RX_ERASURE_EN adds the erase_out signal.
interface qpsk_deint_rx_if
    import wimax_phy_pkg::*;
();

    logic signed [SAMPLE_W-1:0] I_in;
    logic signed [SAMPLE_W-1:0] Q_in;
    logic                       valid_in;
    logic                       ready_in;
    logic                       dataout;
    logic                       sof_out;
    logic                       valid_out;
    logic                       ready_out;
`ifdef RX_ERASURE_EN
    logic                       erase_out;
`endif

    modport master (
        output I_in, Q_in, valid_in, ready_out,
        input  ready_in, dataout, sof_out, valid_out
`ifdef RX_ERASURE_EN
        , input erase_out
`endif
    );

    modport slave (
        input  I_in, Q_in, valid_in, ready_out,
        output ready_in, dataout, sof_out, valid_out
`ifdef RX_ERASURE_EN
        , output erase_out
`endif
    );

endinterface

// File: rtl/qpsk_deint_rx_addr_gen.sv
// Row/column counters that give the natural-order bit addresses of the I and Q bits of the current symbol.
// j=2n always lands on an even row, so both bits share a column and sit one row apart.
module deint_addr_gen
    import wimax_phy_pkg::*;
#(
    parameter int NCBPS = NCBPS_QPSK,
    parameter int D     = INTLV_D
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    output logic [$clog2(NCBPS)-1:0]   k_even,
    output logic [$clog2(NCBPS)-1:0]   k_odd
);

    localparam int ROWS  = NCBPS / D;
    localparam int KW    = $clog2(NCBPS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(D);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (advance) begin
            if (row_q == ROW_W'(ROWS - 2)) begin
                row_d = '0;
                col_d = (col_q == COL_W'(D - 1)) ? '0 : col_q + COL_W'(1);
            end else begin
                row_d = row_q + ROW_W'(2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign k_even = KW'(row_q) * KW'(D) + KW'(col_q);
    assign k_odd  = k_even + KW'(D);

endmodule

// File: rtl/qpsk_deint_rx.sv
// QPSK hard-decision demapper feeding a ping-pong block deinterleaver that streams bits out in natural order.
// Build option: RX_ERASURE_EN adds a per-bit erasure flag array and the erase_out port.
module qpsk_deint_rx
    import wimax_phy_pkg::*;
#(
    parameter int NCBPS = NCBPS_QPSK,
    parameter int D     = INTLV_D
`ifdef RX_ERASURE_EN
    , parameter logic [SAMPLE_W-1:0] ERASE_THR = 16'd4096
`endif
)(
    input  logic           clk,
    input  logic           rst,
    qpsk_deint_rx_if.slave bus
);

    localparam int SYMS  = NCBPS / 2;
    localparam int SYM_W = $clog2(SYMS);
    localparam int KW    = $clog2(NCBPS);
    localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(SYMS - 1);
    localparam logic [KW-1:0]    LAST_BIT = KW'(NCBPS - 1);

    wstate_t            wstate_q, wstate_d;
    logic               wbank_q, wbank_d;
    logic [SYM_W-1:0]   wsym_q, wsym_d;
    rstate_t            rstate_q, rstate_d;
    logic               rbank_q, rbank_d;
    logic [KW-1:0]      rbit_q, rbit_d;
    logic [1:0]         full_q, full_d;
    logic [1:0][NCBPS-1:0] bank_q, bank_d;

    logic               accept;
    logic               wr_done;
    logic               rd_xfer;
    logic               rd_done;
    logic               streaming;
    logic               wr_other_full;
    logic               rd_other_full;
    logic [KW-1:0]      k_even;
    logic [KW-1:0]      k_odd;

    assign bus.ready_in = (wstate_q == W_FILL) && !full_q[wbank_q] && !rst;
    assign accept       = bus.valid_in && bus.ready_in;
    assign wr_done      = accept && (wsym_q == LAST_SYM);

    assign streaming    = (rstate_q == R_STREAM) && !rst;
    assign rd_xfer      = streaming && bus.ready_out;
    assign rd_done      = rd_xfer && (rbit_q == LAST_BIT);

    // Look through a same-edge release/completion so neither side loses a cycle.
    assign wr_other_full = full_q[~wbank_q] && !(rd_done && (rbank_q != wbank_q));
    assign rd_other_full = full_q[~rbank_q] || (wr_done && (wbank_q != rbank_q));

    deint_addr_gen #(
        .NCBPS (NCBPS),
        .D     (D)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (accept),
        .k_even  (k_even),
        .k_odd   (k_odd)
    );

    always_comb begin
        wstate_d = wstate_q;
        wbank_d  = wbank_q;
        wsym_d   = wsym_q;
        case (wstate_q)
            W_FILL: begin
                if (accept) begin
                    if (wsym_q == LAST_SYM) begin
                        wbank_d = ~wbank_q;
                        wsym_d  = '0;
                        if (wr_other_full) begin
                            wstate_d = W_WAIT;
                        end
                    end else begin
                        wsym_d = wsym_q + SYM_W'(1);
                    end
                end
            end
            W_WAIT: begin
                if (!full_q[wbank_q]) begin
                    wstate_d = W_FILL;
                end
            end
            default: wstate_d = W_FILL;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rbank_d  = rbank_q;
        rbit_d   = rbit_q;
        case (rstate_q)
            R_IDLE: begin
                if (full_q[rbank_q]) begin
                    rstate_d = R_STREAM;
                end
            end
            R_STREAM: begin
                if (rd_xfer) begin
                    if (rbit_q == LAST_BIT) begin
                        rbank_d  = ~rbank_q;
                        rbit_d   = '0;
                        rstate_d = rd_other_full ? R_STREAM : R_IDLE;
                    end else begin
                        rbit_d = rbit_q + KW'(1);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // The two flag updates always target different banks, so both may apply on one edge.
    always_comb begin
        full_d = full_q;
        if (wr_done) begin
            full_d[wbank_q] = 1'b1;
        end
        if (rd_done) begin
            full_d[rbank_q] = 1'b0;
        end
    end

    always_comb begin
        bank_d = bank_q;
        if (accept) begin
            bank_d[wbank_q][k_even] = bus.I_in[SAMPLE_W-1];
            bank_d[wbank_q][k_odd]  = bus.Q_in[SAMPLE_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_FILL;
            wbank_q  <= 1'b0;
            wsym_q   <= '0;
            rstate_q <= R_IDLE;
            rbank_q  <= 1'b0;
            rbit_q   <= '0;
            full_q   <= '0;
        end else begin
            wstate_q <= wstate_d;
            wbank_q  <= wbank_d;
            wsym_q   <= wsym_d;
            rstate_q <= rstate_d;
            rbank_q  <= rbank_d;
            rbit_q   <= rbit_d;
            full_q   <= full_d;
        end
    end

    // Bit storage is never read before it is written, so it carries no reset.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign bus.valid_out = streaming;
    assign bus.dataout   = streaming && bank_q[rbank_q][rbit_q];
    assign bus.sof_out   = streaming && (rbit_q == '0);

`ifdef RX_ERASURE_EN
    logic [1:0][NCBPS-1:0] ers_q, ers_d;

    always_comb begin
        ers_d = ers_q;
        if (accept) begin
            ers_d[wbank_q][k_even] = sample_mag(bus.I_in) < ERASE_THR;
            ers_d[wbank_q][k_odd]  = sample_mag(bus.Q_in) < ERASE_THR;
        end
    end

    always_ff @(posedge clk) begin
        ers_q <= ers_d;
    end

    assign bus.erase_out = streaming && ers_q[rbank_q][rbit_q];
`else
    logic unused_ok;
    assign unused_ok = ^{bus.I_in[SAMPLE_W-2:0], bus.Q_in[SAMPLE_W-2:0]};
`endif

endmodule

// File: tb/tb_qpsk_deint_rx.sv
// Scoreboard bench for qpsk_deint_rx: expected bits come from a forward-interleaver reference model.
// Build option: RX_ERASURE_EN also checks erase_out.
module tb_qpsk_deint_rx;

    localparam int NB   = 384;
    localparam int NS   = NB / 2;
    localparam int DCOL = 16;
    localparam int ROWS = NB / DCOL;
    localparam logic signed [15:0] AMP = 16'sd23170;

    typedef struct packed {
        logic d;
        logic sof;
        logic er;
    } exp_t;

    logic clk;
    logic rst;
    qpsk_deint_rx_if bus();

    qpsk_deint_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_fail;
    bit   stuck;
    int   rdy_mode;
    exp_t sb[$];

    logic signed [15:0] blk_i [NS];
    logic signed [15:0] blk_q [NS];
    logic               exp_bit [NB];
    logic               exp_er  [NB];

    logic act_er;
`ifdef RX_ERASURE_EN
    assign act_er = bus.erase_out;
`else
    assign act_er = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Transmit-side first permutation: natural index k goes to received-order index j.
    function automatic int txPerm(input int k);
        return ROWS * (k % DCOL) + k / DCOL;
    endfunction

    function automatic logic isErased(input logic signed [15:0] s);
        int v;
        v = int'(s);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v < 4096;
    endfunction

    task automatic buildRoundTrip();
        logic nat [NB];
        logic tx  [NB];
        for (int k = 0; k < NB; k++) begin
            nat[k] = 1'($urandom_range(0, 1));
            tx[txPerm(k)] = nat[k];
        end
        for (int n = 0; n < NS; n++) begin
            blk_i[n] = tx[2*n]   ? -AMP : AMP;
            blk_q[n] = tx[2*n+1] ? -AMP : AMP;
        end
        for (int k = 0; k < NB; k++) begin
            exp_bit[k] = nat[k];
            exp_er[k]  = 1'b0;
        end
    endtask

    task automatic buildFromSamples();
        logic signed [15:0] sm [NB];
        for (int n = 0; n < NS; n++) begin
            sm[2*n]   = blk_i[n];
            sm[2*n+1] = blk_q[n];
        end
        for (int k = 0; k < NB; k++) begin
            exp_bit[k] = sm[txPerm(k)] < 0;
            exp_er[k]  = isErased(sm[txPerm(k)]);
        end
    endtask

    task automatic pushBlock();
        exp_t e;
        for (int k = 0; k < NB; k++) begin
            e.d   = exp_bit[k];
            e.sof = (k == 0);
`ifdef RX_ERASURE_EN
            e.er  = exp_er[k];
`else
            e.er  = 1'b0;
`endif
            sb.push_back(e);
        end
    endtask

    task automatic sendSym(input logic signed [15:0] i, input logic signed [15:0] q);
        int w;
        if (stuck) return;
        bus.I_in     = i;
        bus.Q_in     = q;
        bus.valid_in = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus.ready_in && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!bus.ready_in) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL sym_accept_timeout: ready_in=0 after %0d cycles, required 1", w);
            stuck = 1'b1;
            bus.valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int nsym, input int gap_max);
        int gap;
        for (int n = 0; n < nsym; n++) begin
            gap = $urandom_range(0, gap_max);
            if (gap > 0) begin
                bus.valid_in = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            sendSym(blk_i[n], blk_q[n]);
            if (n == NS - 1) pushBlock();
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic latencyCheck();
        @(negedge clk);
        checkOutput("latency_not_early", 32'(bus.valid_out), 32'd0);
        @(negedge clk);
        checkOutput("latency_first_bit", 32'({bus.valid_out, bus.sof_out}), 32'd3);
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 8000) begin
            @(posedge clk);
            w++;
        end
        checkOutput("drain_remaining", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.ready_out = 1'b1;
                1: bus.ready_out = 1'($urandom_range(0, 1));
                2: begin
                    if (cnt % 25 == 0) bus.ready_out = ~bus.ready_out;
                    cnt++;
                end
                default: bus.ready_out = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expectation per transfer and checks hold behaviour during stalls.
    logic       prev_stall;
    logic [3:0] prev_out;
    exp_t       got;

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("valid_during_reset", 32'(bus.valid_out), 32'd0);
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_while_stalled",
                            32'({bus.valid_out, bus.dataout, bus.sof_out, act_er}), 32'(prev_out));
            end
            if (bus.valid_out && bus.ready_out) begin
                got.d   = bus.dataout;
                got.sof = bus.sof_out;
                got.er  = act_er;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_bit: actual={d,sof,er}=%0h required=no output", got);
                end else begin
                    checkOutput("bit_d_sof_er", 32'(got), 32'(sb.pop_front()));
                end
            end
            prev_stall = bus.valid_out && !bus.ready_out;
            prev_out   = {bus.valid_out, bus.dataout, bus.sof_out, act_er};
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        stuck    = 1'b0;
        rdy_mode = 0;
        prev_stall = 1'b0;
        bus.I_in = '0;
        bus.Q_in = '0;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        rst = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready_in", 32'(bus.ready_in), 32'd0);
        checkOutput("reset_outputs", 32'({bus.valid_out, bus.sof_out, bus.dataout, act_er}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.ready_in), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] single negative I symbol");
        for (int n = 0; n < NS; n++) begin
            blk_i[n] = AMP;
            blk_q[n] = AMP;
        end
        blk_i[0] = -AMP;
        buildFromSamples();
        applyStimulus(NS, 0);
        latencyCheck();
        waitDrain();

        $display("[TB] random round trips");
        buildRoundTrip();
        applyStimulus(NS, 0);
        latencyCheck();
        waitDrain();
        rdy_mode = 1;
        for (int b = 0; b < 2; b++) begin
            buildRoundTrip();
            applyStimulus(NS, 2);
        end
        waitDrain();
        rdy_mode = 0;

        $display("[TB] zero and boundary samples");
        for (int n = 0; n < NS; n++) begin
            blk_i[n] = $signed(16'($urandom()));
            blk_q[n] = $signed(16'($urandom()));
        end
        blk_i[0] = 16'sd0;
        blk_q[0] = -16'sd1;
        blk_i[1] = 16'sd4095;
        blk_q[1] = 16'sh8000;
        blk_i[2] = 16'sd4096;
        blk_q[2] = -16'sd4095;
        buildFromSamples();
        applyStimulus(NS, 1);
        waitDrain();

        $display("[TB] backpressure");
        rdy_mode = 3;
        for (int b = 0; b < 2; b++) begin
            buildRoundTrip();
            applyStimulus(NS, 0);
        end
        @(negedge clk);
        checkOutput("ready_in_after_two_blocks", 32'(bus.ready_in), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode = 2;
        buildRoundTrip();
        applyStimulus(NS, 0);
        waitDrain();

        $display("[TB] reset mid-block");
        rdy_mode = 3;
        buildRoundTrip();
        applyStimulus(NS, 0);
        buildRoundTrip();
        applyStimulus(100, 0);
        rst = 1'b1;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        checkOutput("ready_after_midblock_reset", 32'(bus.ready_in), 32'd1);
        @(posedge clk);
        #1;
        buildRoundTrip();
        applyStimulus(NS, 1);
        latencyCheck();
        waitDrain();

        $display("[TB] release and completion on the same edge");
        rdy_mode = 0;
        buildRoundTrip();
        applyStimulus(NS, 0);
        repeat (193) @(posedge clk);
        #1;
        buildRoundTrip();
        applyStimulus(NS, 0);
        @(negedge clk);
        checkOutput("same_edge_ready_in", 32'(bus.ready_in), 32'd1);
        checkOutput("same_edge_next_block_sof", 32'({bus.valid_out, bus.sof_out}), 32'd3);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
